// File: rtl/reg_file_hs.sv
// reg_file_hs: valid/ready register file with byte strobes, read-only protection and exposed config registers.
module reg_file_hs #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int NUM_EXPOSED = 4,
  parameter logic [DEPTH-1:0] RO_MASK = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic                         i_req_write,
  input  logic [ADDR_W-1:0]            i_req_addr,
  input  logic [WIDTH-1:0]             i_req_wdata,
  input  logic [WIDTH/8-1:0]           i_req_wstrb,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [WIDTH-1:0]             o_rsp_rdata,
  output logic                         o_rsp_err,
  output logic [NUM_EXPOSED*WIDTH-1:0] o_regs,
  output logic                         o_cfg_update
);
  localparam int NB = WIDTH / 8;
  localparam logic [DEPTH-1:0] ONE = 1;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] rdata_q, rdata_d, rd;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, upd_q, upd_d;
  logic acc, in_range, ro, err, wr_ok;
  assign o_req_ready = !i_rst && (!rsp_valid_q || i_rsp_ready);
  assign acc = i_req_valid && o_req_ready;
  assign in_range = 32'(i_req_addr) < DEPTH;
  // out-of-range addresses shift the one-hot past the mask and read as writable; in_range covers them
  assign ro = |(RO_MASK & (ONE << i_req_addr));
  assign err = !in_range || (i_req_write && ro);
  assign wr_ok = acc && i_req_write && !err;
  always_comb begin
    rd = '0;
    regs_d = regs_q;
    for (int k = 0; k < DEPTH; k++)
      if (32'(i_req_addr) == k) begin
        rd = regs_q[k];
        for (int b = 0; b < NB; b++)
          if (wr_ok && i_req_wstrb[b]) regs_d[k][8*b +: 8] = i_req_wdata[8*b +: 8];
      end
    rsp_valid_d = acc || (rsp_valid_q && !i_rsp_ready);
    rsp_err_d = acc ? err : rsp_err_q;
    rdata_d = acc ? ((i_req_write || err) ? '0 : rd) : rdata_q;
    upd_d = wr_ok && |i_req_wstrb && (32'(i_req_addr) < NUM_EXPOSED);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      regs_q <= '{default: '0};
      rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      rdata_q <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q <= rsp_err_d;
      upd_q <= upd_d;
    end
  end
  for (genvar e = 0; e < NUM_EXPOSED; e++) begin : g_exp
    assign o_regs[e*WIDTH +: WIDTH] = regs_q[e];
  end
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err = rsp_err_q;
  assign o_cfg_update = upd_q;
endmodule
